// File: rtl/alu_result_framer_if.sv
// alu_result_framer_if
//   Groups the framer's two streams:
//     - the ALU result input (valid/ready with 16-bit result and 5-bit flags)
//     - the byte-wide transmit stream (valid/ready) toward the UART transmitter
//   plus the busy status.
// Modports:
//   master : the side that produces results and consumes bytes
//            (an ALU/UART wrapper or a testbench)
//   slave  : the framer itself
interface alu_result_framer_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [4:0]        in_flags;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;

    modport master (
        output in_valid, in_result, in_flags, tx_ready,
        input  in_ready, tx_data, tx_valid, busy
    );

    modport slave (
        input  in_valid, in_result, in_flags, tx_ready,
        output in_ready, tx_data, tx_valid, busy
    );
endinterface

// File: rtl/alu_result_framer.sv
// alu_result_framer
//   Captures one ALU result and its {V,C,N,Z,P} flags, then emits a 5-byte frame
//   on a byte-wide valid/ready stream:
//     HEADER, result[15:8], result[7:0], {3'b000, flags}, XOR checksum.
//   Only one frame is in flight at a time. After each frame there is one idle
//   cycle before the next capture.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : alu_result_framer_if.slave
//          in_valid/in_ready/in_result/in_flags : result input
//          tx_data/tx_valid/tx_ready            : byte output
//          busy                                 : ~in_ready
//   in_ready, tx_valid and tx_data come straight from flops.
module alu_result_framer #(
    parameter int          DATA_W = 16,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    alu_result_framer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HDR, RHI, RLO, FLG, CHK} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] res_q, res_n;
    logic [4:0]        flg_q, flg_n;
    logic [7:0]        acc_q, acc_n;
    logic [7:0]        tx_data_q, tx_data_n;
    logic              tx_valid_q, tx_valid_n;
    logic              in_ready_q, in_ready_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            res_q      <= '0;
            flg_q      <= '0;
            acc_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_n;
            res_q      <= res_n;
            flg_q      <= flg_n;
            acc_q      <= acc_n;
            tx_data_q  <= tx_data_n;
            tx_valid_q <= tx_valid_n;
            in_ready_q <= in_ready_n;
        end
    end

    // acc_q always holds the XOR of every byte presented so far in the frame,
    // including the one currently on tx_data. When FLG transfers, acc_q is
    // therefore the finished checksum. tx_ready only reaches flop inputs.
    always_comb begin
        state_n    = state;
        res_n      = res_q;
        flg_n      = flg_q;
        acc_n      = acc_q;
        tx_data_n  = tx_data_q;
        tx_valid_n = tx_valid_q;
        in_ready_n = in_ready_q;

        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_n    = HDR;
                    res_n      = bus.in_result;
                    flg_n      = bus.in_flags;
                    acc_n      = HEADER;
                    tx_data_n  = HEADER;
                    tx_valid_n = 1'b1;
                    in_ready_n = 1'b0;
                end
            end
            default: begin
                if (tx_valid_q && bus.tx_ready) begin
                    case (state)
                        HDR: begin
                            state_n   = RHI;
                            tx_data_n = res_q[15:8];
                            acc_n     = acc_q ^ res_q[15:8];
                        end
                        RHI: begin
                            state_n   = RLO;
                            tx_data_n = res_q[7:0];
                            acc_n     = acc_q ^ res_q[7:0];
                        end
                        RLO: begin
                            state_n   = FLG;
                            tx_data_n = {3'b000, flg_q};
                            acc_n     = acc_q ^ {3'b000, flg_q};
                        end
                        FLG: begin
                            state_n   = CHK;
                            tx_data_n = acc_q;
                        end
                        default: begin
                            state_n    = IDLE;
                            tx_valid_n = 1'b0;
                            in_ready_n = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    assign bus.in_ready = in_ready_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = ~in_ready_q;
endmodule

// File: tb/tb_alu_result_framer.sv
// tb_alu_result_framer
//   Self-checking bench for alu_result_framer.
//   - Directed tests cover reset, basic and flag frames, backpressure, input
//     held during a frame, and reset in the middle of a frame.
//   - The random test compares every transferred byte against frames built
//     arithmetically from each captured result/flags pair.
module tb_alu_result_framer;
    logic clk = 1'b0;
    logic rst;

    alu_result_framer_if #(.DATA_W(16)) bus ();

    alu_result_framer #(.DATA_W(16), .HEADER(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] got [$];

    // Each byte that transfers on a rising edge is recorded at the falling
    // edge just before it.
    always @(negedge clk) begin
        if (!rst && bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference frame: header, high byte, low byte, flags, XOR of the four.
    function automatic logic [7:0] frame_byte(input logic [15:0] r, input logic [4:0] f, input int idx);
        int hi, lo, fl, ck;
        hi = int'(r) / 256;
        lo = int'(r) % 256;
        fl = int'(f);
        ck = 'hA5 ^ hi ^ lo ^ fl;
        case (idx)
            0:       return 8'hA5;
            1:       return 8'(hi);
            2:       return 8'(lo);
            3:       return 8'(fl);
            default: return 8'(ck);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_result = '0; bus.in_flags = '0; bus.tx_ready = 1'b0;
        #3;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_tests++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", bus.tx_valid); end
        n_tests++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tick(); tick();
        rst = 1'b0;
        tick();
        n_tests++; if (bus.in_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: in_ready=%b tx_valid=%b expected 1/0", bus.in_ready, bus.tx_valid);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [5];
        exp = '{8'hA5, 8'h12, 8'h34, 8'h01, 8'h82};
        bus.tx_ready = 1'b1;
        bus.in_result = 16'h1234; bus.in_flags = 5'b00001; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (bus.tx_data !== exp[i] || bus.tx_valid !== 1'b1) begin
                n_fail++; $display("FAIL basic_byte%0d: got %h/v%b expected %h/v1", i, bus.tx_data, bus.tx_valid, exp[i]);
            end
            n_tests++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++; $display("FAIL basic_busy%0d: in_ready=%b busy=%b expected 0/1", i, bus.in_ready, bus.busy);
            end
            tick();
        end
        n_tests++; if (bus.in_ready !== 1'b1 || bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_end: in_ready=%b tx_valid=%b busy=%b expected 1/0/0", bus.in_ready, bus.tx_valid, bus.busy);
        end
    endtask

    task automatic test_flags();
        logic [7:0] exp [5];
        exp = '{8'hA5, 8'h00, 8'h00, 8'h1B, 8'hBE};
        bus.tx_ready = 1'b1;
        bus.in_result = 16'h0000; bus.in_flags = 5'b11011; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (bus.tx_data !== exp[i] || bus.tx_valid !== 1'b1) begin
                n_fail++; $display("FAIL flags_byte%0d: got %h/v%b expected %h/v1", i, bus.tx_data, bus.tx_valid, exp[i]);
            end
            tick();
        end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flags_end: in_ready=%b expected 1", bus.in_ready); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [5];
        exp = '{8'hA5, 8'h12, 8'h34, 8'h01, 8'h82};
        bus.tx_ready = 1'b1;
        bus.in_result = 16'h1234; bus.in_flags = 5'b00001; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_tests++; if (bus.tx_data !== 8'hA5) begin n_fail++; $display("FAIL bp_hdr: got %h expected a5", bus.tx_data); end
        tick();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (bus.tx_data !== 8'h12 || bus.tx_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold%0d: got %h/v%b expected 12/v1", i, bus.tx_data, bus.tx_valid);
            end
            tick();
        end
        bus.tx_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            n_tests++; if (bus.tx_data !== exp[i] || bus.tx_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_byte%0d: got %h/v%b expected %h/v1", i, bus.tx_data, bus.tx_valid, exp[i]);
            end
            tick();
        end
        n_tests++; if (bus.in_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_end: in_ready=%b tx_valid=%b expected 1/0", bus.in_ready, bus.tx_valid);
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] exp1 [5];
        logic [7:0] exp2 [5];
        exp1 = '{8'hA5, 8'h12, 8'h34, 8'h01, 8'h82};
        exp2 = '{8'hA5, 8'hFF, 8'hFF, 8'h06, 8'hA3};
        bus.tx_ready = 1'b1;
        bus.in_result = 16'h1234; bus.in_flags = 5'b00001; bus.in_valid = 1'b1;
        tick();
        bus.in_result = 16'hFFFF; bus.in_flags = 5'b00110;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (bus.tx_data !== exp1[i] || bus.tx_valid !== 1'b1) begin
                n_fail++; $display("FAIL ign_first%0d: got %h/v%b expected %h/v1", i, bus.tx_data, bus.tx_valid, exp1[i]);
            end
            tick();
        end
        n_tests++; if (bus.in_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL ign_gap: in_ready=%b tx_valid=%b expected 1/0", bus.in_ready, bus.tx_valid);
        end
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (bus.tx_data !== exp2[i] || bus.tx_valid !== 1'b1) begin
                n_fail++; $display("FAIL ign_second%0d: got %h/v%b expected %h/v1", i, bus.tx_data, bus.tx_valid, exp2[i]);
            end
            tick();
        end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ign_end: in_ready=%b expected 1", bus.in_ready); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp [5];
        exp = '{8'hA5, 8'h12, 8'h34, 8'h01, 8'h82};
        bus.tx_ready = 1'b1;
        bus.in_result = 16'h1234; bus.in_flags = 5'b00001; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        n_tests++; if (bus.tx_data !== 8'h34) begin n_fail++; $display("FAIL rstm_rlo: got %h expected 34", bus.tx_data); end
        rst = 1'b1;
        #1;
        n_tests++; if (bus.tx_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.tx_data !== 8'h00) begin
            n_fail++; $display("FAIL rstm_async: tx_valid=%b in_ready=%b busy=%b tx_data=%h expected 0/1/0/00",
                               bus.tx_valid, bus.in_ready, bus.busy, bus.tx_data);
        end
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.tx_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL rstm_residual%0d: tx_valid=%b in_ready=%b expected 0/1", i, bus.tx_valid, bus.in_ready);
            end
        end
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (bus.tx_data !== exp[i] || bus.tx_valid !== 1'b1) begin
                n_fail++; $display("FAIL rstm_byte%0d: got %h/v%b expected %h/v1", i, bus.tx_data, bus.tx_valid, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q [$];
        int   sent;
        int   cyc;
        logic cap;
        got.delete();
        sent = 0;
        cyc  = 0;
        bus.in_valid = 1'b0;
        while (sent < 40 && cyc < 5000) begin
            bus.tx_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid && $urandom_range(0, 2) == 0) begin
                bus.in_result = 16'($urandom);
                bus.in_flags  = 5'($urandom);
                bus.in_valid  = 1'b1;
            end
            cap = bus.in_valid && bus.in_ready;
            if (cap) begin
                for (int b = 0; b < 5; b++) exp_q.push_back(frame_byte(bus.in_result, bus.in_flags, b));
            end
            tick();
            cyc++;
            if (cap) begin
                sent++;
                bus.in_valid = 1'b0;
            end
        end
        n_tests++; if (sent != 40) begin n_fail++; $display("FAIL rand_captures: got %0d expected 40", sent); end
        bus.tx_ready = 1'b1;
        cyc = 0;
        while ((got.size() < exp_q.size() || bus.in_ready !== 1'b1) && cyc < 50) begin
            tick();
            cyc++;
        end
        n_tests++; if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d bytes expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_tests++; if (got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rand_byte%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_backpressure();
        test_busy_ignore();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_result_framer.md
# alu_result_framer

Sequential response framer on the ALU output side of the UART ALU. Accepts one 16-bit ALU result plus its 5-bit flag vector {V, C, N, Z, P} per transaction through a valid/ready handshake. Serializes each transaction into a fixed 5-byte frame on a byte-wide valid/ready stream that feeds the UART transmitter. The frame is header, result high byte, result low byte, flags byte, XOR checksum.

## Interface

Parameters:
- DATA_W, 16, result width; fixed at 16 (two result bytes per frame).
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  result/flags available.
- in_ready  output  1  framer can accept a new result (registered).
- in_result  input  16  ALU result, two's complement.
- in_flags  input  5  {V, C, N, Z, P}, bit 4 = V, bit 0 = P.
- tx_data  output  8  byte to UART transmitter (registered).
- tx_valid  output  1  tx_data valid (registered).
- tx_ready  input  1  UART transmitter accepts byte this cycle.
- busy  output  1  frame in progress; equals ~in_ready.

## Operation

- States: IDLE, HDR, RHI, RLO, FLG, CHK.
- IDLE:
  - in_ready=1, tx_valid=0.
  - On in_valid && in_ready: latch in_result and in_flags into internal registers.
  - Go to HDR and drop in_ready.
- Byte driven in each state:
  - HDR: HEADER.
  - RHI: result[15:8].
  - RLO: result[7:0].
  - FLG: {3'b000, flags[4:0]}.
  - CHK: XOR of the four preceding frame bytes.
- Byte handshake:
  - A byte transfers on a cycle with tx_valid && tx_ready.
  - On transfer the state advances: HDR→RHI→RLO→FLG→CHK→IDLE.
  - The next byte is driven the following cycle with tx_valid still 1.
- Backpressure: while tx_valid && !tx_ready, tx_data and state hold. tx_valid never drops mid-frame.
- Checksum: a running XOR accumulator register is reset to HEADER at capture and updated on each transfer. No combinational path from tx_ready to tx_data.
- CHK transfer: go to IDLE, tx_valid=0 and in_ready=1 the next cycle.
- in_valid while busy: ignored. in_result and in_flags are not sampled. The upstream source must hold its data until in_ready.
- Flags bits 7:5 of the flags byte are always 0.
- Reset, asserted at any time including mid-frame, asynchronously forces:
  - state IDLE, tx_valid=0, tx_data=8'h00, in_ready=1, busy=0.
  - latched result/flags = 0, checksum accumulator = 0.
- No partial frame resumes after reset.

## Timing

- Capture at edge k. Header presented with tx_valid=1 from edge k+1.
- With tx_ready held high, one byte transfers per cycle. Frame occupies edges k+1..k+5 (bytes on tx at k+1..k+5). in_ready returns high after edge k+5.
- Earliest next capture is at edge k+6: one idle cycle between frames. Sustained throughput is 6 cycles per result at full tx_ready.
- Output reset values: in_ready=1, tx_valid=0, tx_data=8'h00, busy=0.
- in_ready, tx_valid and tx_data are all driven from flops. busy is derived from the in_ready flop.
- tx_ready may toggle every cycle. Each byte transfers exactly once, in order.

## Test plan

- in_result=16'h1234, in_flags=5'b00001, tx_ready=1 -> bytes A5, 12, 34, 01, 82 on 5 consecutive cycles. in_ready low for 5 cycles, then high.
- in_result=16'h0000, in_flags=5'b11011 (0x8000+0x8000 case) -> bytes A5, 00, 00, 1B, BE.
- Same stimulus as the first scenario, tx_ready low for 3 cycles while tx_data=12 -> tx_data holds 12, tx_valid holds 1. Sequence and checksum 82 unchanged. Frame ends 3 cycles later.
- in_valid held high with a new value (16'hFFFF, 5'b00110) during a frame -> ignored until the idle cycle. Then captured and framed as A5, FF, FF, 06, checksum A5^FF^FF^06 = A3.
- rst pulsed while RLO is being driven -> tx_valid=0, in_ready=1 immediately. After release, no residual bytes. A new capture of 16'h1234/5'b00001 produces A5, 12, 34, 01, 82.
- Random results/flags with random tx_ready -> scoreboard matches byte order and checksum for every frame. No byte duplicated or dropped.
